// File: rtl/ev20_pkg.sv
// Shared types and sizing constants for the serial FIFO feeder/consumer pair.
package ev20_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SHIFT
    } state_t;

    localparam int FIFO_DEPTH = 4;
    localparam int WORD_W     = 4;

endpackage

// File: rtl/fifo_occ_tracker.sv
// Mirrors the occupancy of a flagless serial FIFO from its push/pop lines.
// Also raises a sticky error when a pop hits an empty FIFO.
module fifo_occ_tracker
    import ev20_pkg::*;
#(
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop_mon,
    output logic [OCC_W-1:0] occ,
    output logic [OCC_W-1:0] occ_next,
    output logic             err
);

    // Next occupancy: pops are ignored while the FIFO is held in clear and
    // an illegal pop on an empty FIFO saturates at zero.
    always_comb begin
        occ_next = occ;
        if (clear) begin
            occ_next = '0;
        end else if (push && !pop_mon) begin
            occ_next = occ + OCC_W'(1);
        end else if (!push && pop_mon && (occ != '0)) begin
            occ_next = occ - OCC_W'(1);
        end
    end

    // Occupancy register and sticky pop-on-empty flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ <= '0;
            err <= 1'b0;
        end else begin
            occ <= occ_next;
            if (pop_mon && !clear && (occ == '0)) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_feeder.sv
// Serializes W-bit words LSB first into a DEPTH-bit serial FIFO, never
// pushing into a full FIFO, and owns the FIFO clear line.
//
// state | meaning
// INIT  | clear asserted to empty the FIFO after reset
// IDLE  | ready=1, waiting for load
// SHIFT | word captured, pushing bits as FIFO space allows
module fifo_feeder
    import ev20_pkg::*;
#(
    parameter int  W     = WORD_W,
    parameter int  DEPTH = FIFO_DEPTH,
    localparam int OCC_W = $clog2(DEPTH + 1),
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [W-1:0]     D,
    input  logic             pop_mon,
    output logic             ready,
    output logic             push,
    output logic             I,
    output logic             clear,
    output logic [OCC_W-1:0] occ,
    output logic             err
);

    state_t           state, state_nx;
    logic [W-1:0]     sh, sh_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             ready_nx, push_nx, i_nx, clear_nx;
    logic [OCC_W-1:0] occ_next;
    logic             room;

    fifo_occ_tracker #(.DEPTH(DEPTH)) u_occ (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .push     (push),
        .pop_mon  (pop_mon),
        .occ      (occ),
        .occ_next (occ_next),
        .err      (err)
    );

    // Space for one more bit once this edge's push and pop have landed.
    assign room = (occ_next < OCC_W'(DEPTH));

    // Next-state and next-output decode; the shift and count only advance
    // on an edge that consumes an issued push.
    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        cnt_nx   = cnt;
        ready_nx = ready;
        push_nx  = 1'b0;
        i_nx     = 1'b0;
        clear_nx = 1'b0;
        case (state)
            INIT: begin
                state_nx = IDLE;
                ready_nx = 1'b1;
            end
            IDLE: begin
                ready_nx = 1'b1;
                if (load) begin
                    sh_nx    = D;
                    cnt_nx   = CNT_W'(W);
                    ready_nx = 1'b0;
                    state_nx = SHIFT;
                    push_nx  = room;
                    i_nx     = room & D[0];
                end
            end
            SHIFT: begin
                if (push) begin
                    sh_nx  = sh >> 1;
                    cnt_nx = cnt - CNT_W'(1);
                end
                if (cnt_nx == '0) begin
                    state_nx = IDLE;
                    ready_nx = 1'b1;
                end else begin
                    push_nx = room;
                    i_nx    = room & sh_nx[0];
                end
            end
            default: begin
                state_nx = INIT;
                clear_nx = 1'b1;
                ready_nx = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any word in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= INIT;
            sh    <= '0;
            cnt   <= '0;
            ready <= 1'b0;
            push  <= 1'b0;
            I     <= 1'b0;
            clear <= 1'b1;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            cnt   <= cnt_nx;
            ready <= ready_nx;
            push  <= push_nx;
            I     <= i_nx;
            clear <= clear_nx;
        end
    end

endmodule

// File: tb/tb_fifo_feeder.sv
// Bench for fifo_feeder: directed scenarios plus a randomized run, with a
// scoreboard of expected pushed bits and an abstract occupancy model.
module tb_fifo_feeder;

    localparam int W     = 4;
    localparam int DEPTH = 4;

    logic         clk;
    logic         reset_n;
    logic         load;
    logic [W-1:0] D;
    logic         pop_mon;
    logic         ready;
    logic         push;
    logic         I;
    logic         clear;
    logic [2:0]   occ;
    logic         err;

    int n_chk = 0;
    int n_err = 0;

    // Scoreboard: bits still owed to the FIFO, in push order.
    bit exp_q[$];
    int m_cnt = 0;
    bit m_err = 1'b0;
    bit exp_push;
    bit got_bit;

    fifo_feeder #(.W(W), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .D       (D),
        .pop_mon (pop_mon),
        .ready   (ready),
        .push    (push),
        .I       (I),
        .clear   (clear),
        .occ     (occ),
        .err     (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs of the current cycle are checked at the falling edge,
    // then the model advances using the inputs presented to the next edge.
    always @(negedge clk) begin
        exp_push = (exp_q.size() != 0) && (m_cnt < DEPTH);
        if (clear === 1'b0) begin
            chk("mon_occ", occ, m_cnt);
            chk("mon_err", err, m_err);
            chk("mon_ready", ready, exp_q.size() == 0);
            chk("mon_push", push, exp_push);
            if (exp_push) begin
                got_bit = exp_q.pop_front();
                if (push === 1'b1) chk("mon_bit", I, got_bit);
            end
        end
        if (reset_n === 1'b0) begin
            exp_q.delete();
            m_cnt = 0;
            m_err = 1'b0;
        end else if (clear === 1'b0) begin
            if (pop_mon && m_cnt == 0) m_err = 1'b1;
            m_cnt = m_cnt + int'(exp_push) - int'(pop_mon);
            if (m_cnt < 0) m_cnt = 0;
            if (ready === 1'b1 && load) begin
                for (int b = 0; b < W; b++) exp_q.push_back(D[b]);
            end
        end
    end

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            if (ready === 1'b1 && exp_q.size() == 0 && m_cnt == 0) ok = 1'b1;
            else begin
                pop_mon = (m_cnt > 0);
                step();
            end
        end
        pop_mon = 1'b0;
        chk(name, ok, 1'b1);
    endtask

    task automatic wait_ready(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (ready === 1'b1) ok = 1'b1;
            else step();
        end
        chk(name, ok, 1'b1);
    endtask

    initial begin
        logic [3:0] w;
        reset_n = 1'b0;
        load    = 1'b0;
        D       = '0;
        pop_mon = 1'b0;

        // Reset release
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("rst_clear", clear, 1'b1);
            chk("rst_push", push, 1'b0);
            chk("rst_ready", ready, 1'b0);
        end
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_clear", clear, 1'b1);
        chk("init_ready", ready, 1'b0);
        step();
        @(negedge clk);
        chk("idle_clear", clear, 1'b0);
        chk("idle_ready", ready, 1'b1);
        chk("idle_occ", occ, 0);

        // Single word 1011, no pops
        step();
        w = 4'b1011;
        load = 1'b1;
        D = w;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w1_push", push, 1'b1);
            chk("w1_bit", I, w[i]);
            chk("w1_occ", occ, i);
            step();
        end
        @(negedge clk);
        chk("w1_ready", ready, 1'b1);
        chk("w1_push_end", push, 1'b0);
        chk("w1_occ_end", occ, 4);

        // Full-FIFO stall with 0110
        step();
        load = 1'b1;
        D = 4'b0110;
        step();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_push", push, 1'b0);
            step();
        end
        pop_mon = 1'b1;
        step();
        pop_mon = 1'b0;
        @(negedge clk);
        chk("stall_occ", occ, 3);
        chk("stall_push_go", push, 1'b1);
        chk("stall_bit", I, 1'b0);
        step();
        drain("stall_drain");

        // Simultaneous push and pop at occupancy 2
        load = 1'b1;
        D = 4'($urandom);
        step();
        load = 1'b0;
        wait_ready("sim_fill");
        pop_mon = 1'b1;
        step();
        step();
        pop_mon = 1'b0;
        @(negedge clk);
        chk("sim_occ_pre", occ, 2);
        step();
        load = 1'b1;
        D = 4'($urandom);
        step();
        load = 1'b0;
        pop_mon = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("sim_push", push, 1'b1);
            chk("sim_occ", occ, 2);
            step();
        end
        pop_mon = 1'b0;
        @(negedge clk);
        chk("sim_occ_end", occ, 2);
        chk("sim_err", err, 1'b0);
        chk("sim_ready", ready, 1'b1);

        // Illegal pop on empty FIFO
        step();
        pop_mon = 1'b1;
        step();
        step();
        step();
        pop_mon = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk("ill_err", err, 1'b1);
            chk("ill_occ", occ, 0);
            step();
        end

        // Reset mid-word
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        step();
        load = 1'b1;
        D = 4'b1101;
        step();
        load = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        step();
        @(negedge clk);
        chk("mid_push", push, 1'b0);
        chk("mid_clear", clear, 1'b1);
        chk("mid_occ", occ, 0);
        chk("mid_ready", ready, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("mid_nopush", push, 1'b0);
            step();
        end

        // Randomized traffic, load offered regardless of ready
        for (int i = 0; i < 600; i++) begin
            load    = ($urandom_range(0, 3) == 0);
            D       = 4'($urandom);
            pop_mon = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            step();
        end
        load = 1'b0;
        drain("rand_drain");
        chk("rand_err", err, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fifo_feeder.md
# fifo_feeder

Upstream stage of the 1-bit, 4-deep serial FIFO. Accepts a 4-bit word over a ready/load handshake and pushes it into the FIFO one bit per cycle, LSB first. It mirrors FIFO occupancy from the downstream `pop` line and never pushes into a full FIFO, because the FIFO itself has no full or empty flags. It also owns the FIFO `clear` line and flags downstream pops on an empty FIFO.

## Interface
- `W`, 4: word width in bits; equals bits pushed per word.
- `DEPTH`, 4: FIFO capacity in bits; must match the downstream FIFO.

Ports:
- `clk` in 1: single clock; all state changes on its posedge.
- `reset_n` in 1: reset; synchronous, active-low.
- `load` in 1: word-valid request; sampled only when `ready`=1.
- `D` in W: word to serialize.
- `pop_mon` in 1: copy of the net driving the FIFO `pop` input.
- `ready` out 1: block can accept a word this cycle.
- `push` out 1: drives FIFO `push`.
- `I` out 1: drives FIFO `I`; valid when `push`=1.
- `clear` out 1: drives FIFO `clear`.
- `occ` out clog2(DEPTH+1): tracked FIFO occupancy, 0..DEPTH.
- `err` out 1: sticky protocol error (pop on empty FIFO).

## Operation
- All outputs are registered.
- **Reset values** (edge with `reset_n`=0): state INIT, `clear`=1, `push`=0, `I`=0, `ready`=0, `occ`=0, `err`=0, shift register and bit counter 0.
- **INIT:** first edge with `reset_n`=1 moves to IDLE. That edge sets `clear`=0 and `ready`=1. `pop_mon` is ignored while `clear`=1, because the FIFO discards its effect.
- **IDLE:** `ready`=1. On an edge where `load`=1:
  - capture `D` into the shift register and set bit counter = W;
  - set `ready`=0 and go to SHIFT.
  - Push decision is made on the same edge (see below).
- **SHIFT**, evaluated at every edge:
  - `occ_next` = `occ` + `push` − `pop_mon`, using the current output values.
  - Next `push` = (bits remaining after this edge > 0) and (`occ_next` < DEPTH).
  - When a push is issued, `I` = shift register bit 0. The shift and bit-counter decrement happen on the edge that consumes that push, i.e. the edge where `push`=1.
  - When the bit counter reaches 0, next `push`=0, `ready`=1, and the state returns to IDLE.
- **Occupancy:** `occ` <= `occ_next` every edge outside INIT. It saturates at 0 on an illegal pop and never exceeds DEPTH by construction.
- **Simultaneous push and pop:** legal only when `occ` ≥ 1, matching the FIFO rule that pop is performed before push. `occ` is unchanged.
- **Error flag:** `err` <= 1 on any edge with `pop_mon`=1, `occ`=0 and `clear`=0, whether or not `push`=1. It stays set until reset.
- **`load` while `ready`=0:** ignored; the word is not captured.
- **Reset mid-word:** the word is dropped, `clear` is reasserted so the FIFO is emptied, and `occ`=0.

## Timing
- Load on edge k, space available: `push`=1 with `I`=D[0] during cycle k+1. D[1..3] follow in cycles k+2..k+4.
- `ready`=1 again in cycle k+5. Minimum word period is therefore 5 cycles.
- Full-FIFO stall: `push` stays 0 until an edge where `pop_mon`=1. `push`=1 in the following cycle, with the same bit.
- Pushed bit reaches FIFO output `P` per the FIFO's own timing; this block does not observe `P`.
- `clear` is high only during reset and for the INIT cycle. Data is pushed at the earliest one cycle after `ready` first rises.

## Structure
- Shared package `ev20_pkg`:
  - state enum {INIT, IDLE, SHIFT};
  - constants `FIFO_DEPTH`=4 and `WORD_W`=4, used as the defaults for DEPTH and W.
- Sub-module `fifo_occ_tracker`:
  - inputs: `clk`, `reset_n`, `clear`, `push`, `pop_mon`;
  - outputs: `occ`, `occ_next`, `err`.
  - The FIFO consumer stage reuses it.
- The top level holds the FSM, the shift register and the bit counter.

## Test plan
1. **Reset release:** hold `reset_n`=0 for 3 cycles, then release.
   - During reset: `clear`=1, `push`=0, `ready`=0.
   - First cycle after release: `clear`=1, `ready`=0.
   - Next cycle: `clear`=0, `ready`=1, `occ`=0.
2. **Single word:** `load`=1, D=4'b1011, `pop_mon`=0.
   - `push`=1 for 4 cycles with `I`=1,1,0,1.
   - `occ` steps 1,2,3,4.
   - `ready`=1 in cycle 5, then `push` stays 0.
3. **Full-FIFO stall:** with `occ`=4, load D=4'b0110.
   - `push` stays 0.
   - Pulse `pop_mon` for 1 cycle: `occ`=3, next cycle `push`=1 with `I`=0.
4. **Simultaneous push and pop:** at `occ`=2, assert `pop_mon` in each push cycle.
   - `occ` stays 2 across the whole word; `err`=0.
5. **Illegal pop:** `pop_mon`=1 at `occ`=0.
   - `err`=1 on the next edge and stays 1 for 20 more cycles.
   - `occ` stays 0.
6. **Reset mid-word:** assert `reset_n`=0 after 2 of 4 bits are pushed.
   - Next cycle: `push`=0, `clear`=1, `occ`=0, `ready`=0.
   - After release, no remaining bits of the dropped word are pushed.
